game_master_fsm_param: RTL and testbench
========================================

# game_master_fsm_param

Parametrised game master state machine for the 2D shooter: sequences round start, aiming, shooting, scoring, lives and end of game for `N_TARGETS` targets plus one bullet and one torpedo sprite. It sits between the key inputs, the sprite units (position writes, velocity writes, update enables, on-screen and collision flags) and the end-of-game timer. It drives the score and win/over indicators to the display logic.

## Interface
- `N_TARGETS`, 3: number of target sprites, 1..8.
- `SCORE_W`, 4: score counter width.
- `WIN_SCORE`, 3: score that wins the game. Must satisfy 1 ≤ `WIN_SCORE` ≤ 2^`SCORE_W`−1; elaboration fails otherwise.
- `N_LIVES`, 3: missed shots allowed before loss, ≥1. `LIVES_W` = $clog2(`N_LIVES`+1).

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `launch_key` in 1: fire / restart key, level.
- `target_within_screen` in `N_TARGETS`: per-target on-screen flag.
- `bullet_within_screen`, `torpedo_within_screen` in 1 each.
- `collision` in 1: torpedo–target collision; the game is lost.
- `target_hit` in `N_TARGETS`: bullet hit on target i.
- `end_of_game_timer_running` in 1.
- `target_write_xy`, `target_write_dxy`, `target_enable_update` out `N_TARGETS` each.
- `bullet_write_xy`, `bullet_write_dxy`, `bullet_enable_update` out 1 each.
- `torpedo_write_xy`, `torpedo_write_dxy`, `torpedo_enable_update` out 1 each.
- `end_of_game_timer_start` out 1: one-cycle pulse.
- `score` out `SCORE_W`.
- `lives` out `LIVES_W`.
- `game_won` out 1.
- `game_over` out 1.

## Operation
- States: START_GAME, START_ROUND, AIM, SHOOT, END_ROUND, END_GAME.
- `launch_edge` = `launch_key` & ~`launch_key_q`. `launch_key_q` is a register that resets to 1, so a key held through reset does not fire.
- `timer_seen` is set when `end_of_game_timer_running`=1 and cleared in START_GAME. `timeout` = `timer_seen` & ~`end_of_game_timer_running`.
- START_GAME (1 cycle):
  - score←0, lives←`N_LIVES`, game_won←0, game_over←0.
  - Pulse `end_of_game_timer_start`.
  - Next state: START_ROUND.
- START_ROUND (1 cycle):
  - Assert all `target_write_xy`, `bullet_write_xy`, `torpedo_write_xy`, and all `target_write_dxy`.
  - Next state: AIM.
- AIM:
  - Assert all `target_enable_update`.
  - Priority: `timeout`|`collision` → END_GAME (lost); else `launch_edge` → SHOOT.
- SHOOT:
  - `bullet_write_dxy` and `torpedo_write_dxy` are asserted on the first SHOOT cycle only.
  - All enable_update outputs are asserted.
  - Priority:
    1. `timeout`|`collision` → END_GAME (lost).
    2. |`target_hit` → score+1, then END_ROUND. Simultaneous hits on several targets count once.
    3. Any sprite off-screen → lives−1. If the new lives value is 0 → END_GAME (lost); else START_ROUND.
- END_ROUND (1 cycle):
  - score==`WIN_SCORE` → END_GAME with game_won←1; else START_ROUND.
- END_GAME:
  - game_over=1 and game_won is held. No sprite strobes.
  - `launch_edge` → START_GAME.
- Arithmetic: score saturates at 2^`SCORE_W`−1. lives never decrements below 0.

## Timing
- All outputs are registered and computed from the next-state decode, so they are valid in the same cycle the state register holds the corresponding state.
- Reset: state=START_GAME, score=0, lives=`N_LIVES`, game_won=0, game_over=0, all strobes/enables=0, `timer_seen`=0.
- The first START_GAME pulse appears 1 cycle after `rst` deasserts.
- Decision latency: an input sampled at edge k changes state and outputs at edge k+1.
- SHOOT → START_ROUND → AIM takes 2 cycles minimum. `launch_edge` is not accepted during START_ROUND.
- `rst` asserted mid-game overrides everything on the next edge. A partial strobe pattern is never left behind.

## Structure
- Package `game_master_pkg`:
  - `state_t` enum.
  - `score_t`/`lives_t` width helpers.
  - A popcount-free `any_hit` function.
- Sub-module `game_key_edge_detect` (parameter `RESET_LEVEL`) produces `launch_edge`.
- FSM, counters and output registers stay in one module.

## Test plan
- Default parameters, reset, hold `end_of_game_timer_running`=1, launch edge, `target_hit`=3'b001 in SHOOT → score 0→1, END_ROUND, START_ROUND with all write_xy for 1 cycle.
- Three successful rounds → score=3, game_won=1, game_over=1. Launch edge → all cleared, `end_of_game_timer_start` pulses once.
- Three shots ending with `bullet_within_screen`=0 → lives 3→2→1→0, game_over=1, game_won=0, score unchanged.
- In SHOOT, `collision`=1 and `target_hit`=1 on the same cycle → END_GAME lost, score not incremented.
- Timer running, then `end_of_game_timer_running` falls during AIM → END_GAME next cycle. Timer low from the start (`timer_seen`=0) → no timeout.
- `N_TARGETS`=5, `SCORE_W`=2, `WIN_SCORE`=3: `rst` asserted mid-SHOOT → all outputs at reset values next edge. `launch_key` held across reset → no SHOOT.

Source files
------------

// File: rtl/game_master_pkg.sv
// game_master_pkg: shared states and helpers for the shooter game master.
package game_master_pkg;
  typedef enum logic [2:0] {START_GAME, START_ROUND, AIM, SHOOT, END_ROUND, END_GAME} state_t;
  function automatic int lives_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic int score_max(int w);
    return (1 << w) - 1;
  endfunction
  function automatic logic any_hit(logic [7:0] v);
    return |v;
  endfunction
endpackage

// File: rtl/game_key_edge_detect.sv
// game_key_edge_detect: rising-edge pulse of a level key, register seeded with RESET_LEVEL.
module game_key_edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);
  logic key_q;
  always_ff @(posedge clk)
    key_q <= rst ? RESET_LEVEL : key;
  assign rise = key & ~key_q;
endmodule

// File: rtl/game_master_fsm_param.sv
// game_master_fsm_param: round/score/lives sequencer with registered strobes decoded from the next state.
module game_master_fsm_param
  import game_master_pkg::*;
#(
  parameter int N_TARGETS = 3,
  parameter int SCORE_W = 4,
  parameter int WIN_SCORE = 3,
  parameter int N_LIVES = 3,
  localparam int LIVES_W = lives_w(N_LIVES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  input  logic [N_TARGETS-1:0] target_within_screen,
  input  logic                 bullet_within_screen,
  input  logic                 torpedo_within_screen,
  input  logic                 collision,
  input  logic [N_TARGETS-1:0] target_hit,
  input  logic                 end_of_game_timer_running,
  output logic [N_TARGETS-1:0] target_write_xy,
  output logic [N_TARGETS-1:0] target_write_dxy,
  output logic [N_TARGETS-1:0] target_enable_update,
  output logic                 bullet_write_xy,
  output logic                 bullet_write_dxy,
  output logic                 bullet_enable_update,
  output logic                 torpedo_write_xy,
  output logic                 torpedo_write_dxy,
  output logic                 torpedo_enable_update,
  output logic                 end_of_game_timer_start,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic                 game_won,
  output logic                 game_over
);
  if (WIN_SCORE < 1 || WIN_SCORE > score_max(SCORE_W)) begin : g_bad_win
    $error("WIN_SCORE out of range for SCORE_W");
  end
  if (N_TARGETS < 1 || N_TARGETS > 8 || N_LIVES < 1) begin : g_bad_cfg
    $error("N_TARGETS or N_LIVES out of range");
  end
  state_t state, next_state;
  logic fresh, timer_seen, launch_edge, timeout, lost, hit, off_screen, do_hit, do_miss;
  logic [LIVES_W-1:0] lives_dec;
  game_key_edge_detect #(.RESET_LEVEL(1'b1)) u_key (
    .clk(clk), .rst(rst), .key(launch_key), .rise(launch_edge)
  );
  always_comb begin
    timeout = timer_seen & ~end_of_game_timer_running;
    lost = timeout | collision;
    hit = any_hit(8'(target_hit));
    off_screen = ~&target_within_screen | ~bullet_within_screen | ~torpedo_within_screen;
    lives_dec = lives - LIVES_W'(lives != '0);
    next_state = state;
    case (state)
      START_GAME:  next_state = fresh ? START_GAME : START_ROUND;
      START_ROUND: next_state = AIM;
      AIM:         next_state = lost ? END_GAME : launch_edge ? SHOOT : AIM;
      SHOOT:       next_state = lost ? END_GAME : hit ? END_ROUND :
                                off_screen ? (lives_dec == '0 ? END_GAME : START_ROUND) : SHOOT;
      END_ROUND:   next_state = score == SCORE_W'(WIN_SCORE) ? END_GAME : START_ROUND;
      END_GAME:    next_state = launch_edge ? START_GAME : END_GAME;
      default:     next_state = START_GAME;
    endcase
    do_hit = state == SHOOT && !lost && hit;
    do_miss = state == SHOOT && !lost && !hit && off_screen;
  end
  // fresh holds START_GAME for one extra edge so reset is followed by a timer-start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START_GAME;
      fresh <= 1'b1;
      timer_seen <= 1'b0;
      score <= '0;
      lives <= LIVES_W'(N_LIVES);
      game_won <= 1'b0;
      game_over <= 1'b0;
      end_of_game_timer_start <= 1'b0;
      target_write_xy <= '0;
      target_write_dxy <= '0;
      target_enable_update <= '0;
      bullet_write_xy <= 1'b0;
      bullet_write_dxy <= 1'b0;
      bullet_enable_update <= 1'b0;
      torpedo_write_xy <= 1'b0;
      torpedo_write_dxy <= 1'b0;
      torpedo_enable_update <= 1'b0;
    end else begin
      state <= next_state;
      fresh <= 1'b0;
      timer_seen <= (state != START_GAME) & (timer_seen | end_of_game_timer_running);
      score <= next_state == START_GAME ? '0 : do_hit && score != '1 ? score + SCORE_W'(1) : score;
      lives <= next_state == START_GAME ? LIVES_W'(N_LIVES) : do_miss ? lives_dec : lives;
      game_won <= next_state != START_GAME && (game_won || (state == END_ROUND && next_state == END_GAME));
      game_over <= next_state == END_GAME;
      end_of_game_timer_start <= next_state == START_GAME;
      target_write_xy <= {N_TARGETS{next_state == START_ROUND}};
      target_write_dxy <= {N_TARGETS{next_state == START_ROUND}};
      target_enable_update <= {N_TARGETS{next_state == AIM || next_state == SHOOT}};
      bullet_write_xy <= next_state == START_ROUND;
      bullet_write_dxy <= next_state == SHOOT && state != SHOOT;
      bullet_enable_update <= next_state == SHOOT;
      torpedo_write_xy <= next_state == START_ROUND;
      torpedo_write_dxy <= next_state == SHOOT && state != SHOOT;
      torpedo_enable_update <= next_state == SHOOT;
    end
  end
endmodule

// File: tb/tb_game_master_fsm_param.sv
// tb_game_master_fsm_param: vector table with scoreboard on default config, hand sequences on a 5-target config.
module tb_game_master_fsm_param;
  typedef enum int {P_RST, P_SG, P_SR, P_AIM, P_SH1, P_SH, P_ER, P_EG} ph_t;
  typedef struct {
    logic key, bws, coll, run;
    logic [2:0] hit;
    ph_t ph;
    int sc, lv;
    logic won;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic rst = 1'b1, key = 1'b0, bws = 1'b1, coll = 1'b0, run = 1'b1;
  logic [2:0] hit = '0;
  logic [2:0] txy, tdxy, ten;
  logic bxy, bdxy, ben, pxy, pdxy, pen, tstart, won, over;
  logic [3:0] score;
  logic [1:0] lives;
  logic [23:0] obs;
  assign obs = {tstart, txy, tdxy, ten, bxy, bdxy, ben, pxy, pdxy, pen, score, lives, won, over};
  game_master_fsm_param dut (
    .clk(clk), .rst(rst), .launch_key(key), .target_within_screen(3'b111),
    .bullet_within_screen(bws), .torpedo_within_screen(1'b1), .collision(coll),
    .target_hit(hit), .end_of_game_timer_running(run),
    .target_write_xy(txy), .target_write_dxy(tdxy), .target_enable_update(ten),
    .bullet_write_xy(bxy), .bullet_write_dxy(bdxy), .bullet_enable_update(ben),
    .torpedo_write_xy(pxy), .torpedo_write_dxy(pdxy), .torpedo_enable_update(pen),
    .end_of_game_timer_start(tstart), .score(score), .lives(lives),
    .game_won(won), .game_over(over)
  );
  logic rst2 = 1'b1, key2 = 1'b0;
  logic [4:0] txy2, tdxy2, ten2;
  logic bxy2, bdxy2, ben2, pxy2, pdxy2, pen2, tstart2, won2, over2;
  logic [1:0] score2, lives2;
  game_master_fsm_param #(.N_TARGETS(5), .SCORE_W(2), .WIN_SCORE(3)) dut2 (
    .clk(clk), .rst(rst2), .launch_key(key2), .target_within_screen(5'h1f),
    .bullet_within_screen(1'b1), .torpedo_within_screen(1'b1), .collision(1'b0),
    .target_hit(5'h00), .end_of_game_timer_running(1'b0),
    .target_write_xy(txy2), .target_write_dxy(tdxy2), .target_enable_update(ten2),
    .bullet_write_xy(bxy2), .bullet_write_dxy(bdxy2), .bullet_enable_update(ben2),
    .torpedo_write_xy(pxy2), .torpedo_write_dxy(pdxy2), .torpedo_enable_update(pen2),
    .end_of_game_timer_start(tstart2), .score(score2), .lives(lives2),
    .game_won(won2), .game_over(over2)
  );
  function automatic logic [23:0] expv(ph_t p, int sc, int lv, logic w);
    logic sr = p == P_SR;
    logic sh = p == P_SH1 || p == P_SH;
    logic en = sh || p == P_AIM;
    logic f = p == P_SH1;
    return {p == P_SG, {3{sr}}, {3{sr}}, {3{en}}, sr, f, sh, sr, f, sh, 4'(sc), 2'(lv), w, p == P_EG};
  endfunction
  function automatic vec_t mk(logic k, logic b, logic c, logic r, logic [2:0] h, ph_t p, int sc, int lv, logic w);
    vec_t v;
    v.key = k; v.bws = b; v.coll = c; v.run = r; v.hit = h; v.ph = p; v.sc = sc; v.lv = lv; v.won = w;
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  vec_t tbl[$];
  logic [23:0] sb[$];
  initial begin
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, P_ER, 1, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 1, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 1, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 1, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SH, 1, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3'b110, P_ER, 2, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 2, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 2, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 2, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 3'b100, P_ER, 3, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_EG, 3, 3, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_EG, 3, 3, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_EG, 3, 3, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, P_SR, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 2, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, P_SR, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, P_EG, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SH1, 0, 3, 0));
    tbl.push_back(mk(1, 1, 1, 1, 3'b001, P_EG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_EG, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, P_SG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_SR, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P_EG, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, P_SG, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P_SR, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P_AIM, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, P_AIM, 0, 3, 0));
    tick();
    tick();
    chk("reset_state", 32'(obs), 32'(expv(P_RST, 0, 3, 0)));
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      key = tbl[i].key; bws = tbl[i].bws; coll = tbl[i].coll; run = tbl[i].run; hit = tbl[i].hit;
      sb.push_back(expv(tbl[i].ph, tbl[i].sc, tbl[i].lv, tbl[i].won));
      tick();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(sb.pop_front()));
    end
    tick();
    tick();
    chk("rst2_state", 32'({tstart2, ten2, over2, won2, score2, lives2}), 32'({1'b0, 5'h00, 1'b0, 1'b0, 2'd0, 2'd3}));
    rst2 = 1'b0;
    tick();
    chk("rst2_first_pulse", 32'(tstart2), 32'(1));
    tick();
    chk("rst2_round_xy", 32'({txy2, tdxy2, bxy2, pxy2}), 32'({5'h1f, 5'h1f, 1'b1, 1'b1}));
    tick();
    chk("rst2_aim", 32'({ten2, ben2}), 32'({5'h1f, 1'b0}));
    key2 = 1'b1;
    tick();
    chk("rst2_shoot", 32'({ten2, ben2, pen2, bdxy2, pdxy2}), 32'({5'h1f, 4'hf}));
    rst2 = 1'b1;
    tick();
    chk("rst2_mid_shoot", 32'({tstart2, txy2, tdxy2, ten2, bxy2, bdxy2, ben2, pxy2, pdxy2, pen2, score2, lives2, won2, over2}),
        32'({17'h0, 6'h0, 2'd0, 2'd3, 2'b00}));
    tick();
    rst2 = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("held_key_no_shoot%0d", i), 32'({ten2, ben2, bdxy2, over2}), 32'({5'h1f, 3'b000}));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
